// File: rtl/prom_pkg.sv
// Shared types and constants for the program ROM: FSM states, the NOP word
// returned for idle/out-of-range fetches, and the default word depth.
package prom_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} prom_state_e;
  localparam logic [31:0] NOP            = 32'h0;
  localparam int          PROM_DEPTH_DEF = 1024;
endpackage

// File: rtl/prom_mem.sv
// Single-port DEPTH x 32 synchronous RAM. Write has priority; the read data
// register only updates on non-write cycles. Contents are not reset.
module prom_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    else      rdata_q       <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/prom.sv
// Program ROM: byte-stream loader (IDLE/LOAD/RUN FSM, little-endian word
// assembly, write pointer) in front of a single-port RAM serving CPU fetches.
module prom
  import prom_pkg::*;
#(
  parameter int DEPTH = PROM_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [15:0]   prom_addr,
  output logic [31:0]   instruction,
  output logic          addr_err,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  input  logic          ld_done,
  output logic          running,
  output logic [AW:0]   word_count
);
  prom_state_e   state_q, state_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   wc_q, wc_d;
  logic [31:0]   asm_q, asm_d;
  logic          rd_ok_q, err_q;

  logic          xfer, we, in_rng;
  logic [2:0]    nb;
  logic [31:0]   wdata, rdata;
  logic [AW-1:0] maddr;

  assign in_rng = {16'b0, prom_addr} < 32'(DEPTH);

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    ptr_d   = ptr_q;
    wc_d    = wc_q;
    asm_d   = asm_q;
    xfer    = (state_q == LOAD) && ld_valid;
    // Flush on the 4th byte, or on ld_done with at least one byte pending.
    we      = (state_q == LOAD) && !ld_start &&
              ((xfer && bcnt_q == 2'd3) || (ld_done && (xfer || bcnt_q != 2'd0)));
    if (xfer) asm_d[{bcnt_q, 3'b000} +: 8] = ld_data;
    nb = {1'b0, bcnt_q} + {2'b0, xfer};
    wdata = '0;
    for (int j = 0; j < 4; j++)
      if (3'(j) < nb) wdata[8*j +: 8] = asm_d[8*j +: 8];

    if (ld_start) begin
      state_d = LOAD;
      bcnt_d  = '0;
      ptr_d   = '0;
      wc_d    = '0;
    end else if (state_q == LOAD) begin
      if (xfer) bcnt_d = bcnt_q + 2'd1;
      if (we) begin
        bcnt_d = '0;
        ptr_d  = ptr_q + 1'b1;
        wc_d   = wc_q + 1'b1;
      end
      if (ld_done || (we && ptr_q == AW'(DEPTH - 1))) state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      ptr_q   <= '0;
      wc_q    <= '0;
      asm_q   <= '0;
      rd_ok_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      ptr_q   <= ptr_d;
      wc_q    <= wc_d;
      asm_q   <= asm_d;
      rd_ok_q <= (state_q == RUN) && in_rng;
      err_q   <= (state_q == RUN) && !in_rng;
    end
  end

  assign maddr = we ? ptr_q : prom_addr[AW-1:0];

  prom_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (we),
    .addr_i  (maddr),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );

  // Gate with current state so a fetch issued just before a reload never leaks out.
  assign instruction = (rd_ok_q && state_q == RUN) ? rdata : NOP;
  assign addr_err    = err_q && (state_q == RUN);
  assign ld_ready    = (state_q == LOAD);
  assign running     = (state_q == RUN);
  assign word_count  = wc_q;
endmodule
